// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and helpers for the LEGv8 pipeline hazard controller.
//   fwd_sel_t   : operand source select (regfile / EX ALU result / MEM result)
//   sb_entry_t  : one scoreboard entry {valid, regwrite, rd, load, setflag}
//   XZR_IDX     : zero-register index, never a hazard source
//   is_producer : true when an entry will write a given (non-XZR) register
package hazard_pkg;

  localparam int REG_W_P = 5;
  localparam int unsigned XZR_IDX = 31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic [REG_W_P-1:0] rd;
    logic               load;
    logic               setflag;
  } sb_entry_t;

  localparam int SB_W = $bits(sb_entry_t);

  function automatic logic is_producer(
    input logic               vld,
    input logic               rw,
    input logic [REG_W_P-1:0] rd,
    input logic [REG_W_P-1:0] r,
    input logic [REG_W_P-1:0] xzr
  );
    return vld & rw & (rd == r) & (r != xzr);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Three-entry shift register tracking the destinations of instructions in
// EX, MEM and WB. The EX entry captures the RF instruction, or a bubble
// (invalid entry) whenever the RF instruction is being stalled.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (clears valids)
//   i_stall          : RF instruction held this cycle, insert a bubble
//   i_rf_valid       : RF holds a real instruction
//   i_rf_regwrite    : RF instruction writes i_rf_rd
//   i_rf_rd          : RF destination register
//   i_rf_load        : RF instruction is a load
//   i_rf_setflag     : RF instruction sets flags
//   o_ex/o_mem/o_wb  : packed sb_entry_t for each downstream stage
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_stall,
  input  logic               i_rf_valid,
  input  logic               i_rf_regwrite,
  input  logic [REG_W_P-1:0] i_rf_rd,
  input  logic               i_rf_load,
  input  logic               i_rf_setflag,
  output logic [SB_W-1:0]    o_ex,
  output logic [SB_W-1:0]    o_mem,
  output logic [SB_W-1:0]    o_wb
);

  // Valid bits are control and get reset; the payload fields are not.
  logic              r_vld_p0, r_vld_p1, r_vld_p2;
  logic [SB_W-2:0]   r_dat_p0, r_dat_p1, r_dat_p2;

  // EX capture (p0) -> MEM (p1) -> WB (p2)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= i_rf_valid & ~i_stall;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_dat_p0 <= {i_rf_regwrite, i_rf_rd, i_rf_load, i_rf_setflag};
    r_dat_p1 <= r_dat_p0;
    r_dat_p2 <= r_dat_p1;
  end

  assign o_ex  = {r_vld_p0, r_dat_p0};
  assign o_mem = {r_vld_p1, r_dat_p1};
  assign o_wb  = {r_vld_p2, r_dat_p2};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard controller for the five-stage LEGv8 pipeline. Compares the RF
// instruction's register/flag reads against the scoreboarded EX/MEM
// destinations and drives forwarding selects plus stall/bubble.
// Build option: HAZ_FWD_EN -- when defined, operands and flags are forwarded
// and only load-use stalls; when undefined, all selects are 0 and any EX/MEM
// dependency stalls until the producer has left MEM.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   rf_valid          : RF stage holds a real instruction
//   rf_ra, rf_rb      : read addresses; rf_use_a/rf_use_b qualify them
//   rf_use_flags      : B.cond in RF
//   rf_regwrite/rf_rd : RF destination
//   rf_load           : RF instruction is LDUR/LDURB
//   rf_setflag        : RF instruction sets flags
//   stall             : hold PC and IF2RF
//   bubble            : load NOP into RF2EX (always equals stall)
//   fwd_a, fwd_b      : 00 regfile, 01 EX ALU result, 10 MEM result
//   fwd_flags         : 1 = live EX flags, 0 = flag register
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int          REG_W = 5,
  parameter int unsigned XZR   = XZR_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rf_valid,
  input  logic [REG_W-1:0] rf_ra,
  input  logic [REG_W-1:0] rf_rb,
  input  logic             rf_use_a,
  input  logic             rf_use_b,
  input  logic             rf_use_flags,
  input  logic             rf_regwrite,
  input  logic [REG_W-1:0] rf_rd,
  input  logic             rf_load,
  input  logic             rf_setflag,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_flags
);

  localparam logic [REG_W-1:0] XZR_R = REG_W'(XZR);

  sb_entry_t       w_ex, w_mem;
  logic [SB_W-1:0] w_wb;
  logic            w_stall;
  fwd_sel_t        w_fwd_a, w_fwd_b;
  logic            w_fwd_flags;
  logic            w_a_ex, w_a_mem, w_b_ex, w_b_mem;
  logic            w_unused;

  hazard_scoreboard u_sb (
    .clk           (clk),
    .reset         (reset),
    .i_stall       (w_stall),
    .i_rf_valid    (rf_valid),
    .i_rf_regwrite (rf_regwrite),
    .i_rf_rd       (rf_rd),
    .i_rf_load     (rf_load),
    .i_rf_setflag  (rf_setflag),
    .o_ex          (w_ex),
    .o_mem         (w_mem),
    .o_wb          (w_wb)
  );

  always_comb begin
    w_a_ex  = rf_use_a & is_producer(w_ex.valid,  w_ex.regwrite,  w_ex.rd,  rf_ra, XZR_R);
    w_a_mem = rf_use_a & is_producer(w_mem.valid, w_mem.regwrite, w_mem.rd, rf_ra, XZR_R);
    w_b_ex  = rf_use_b & is_producer(w_ex.valid,  w_ex.regwrite,  w_ex.rd,  rf_rb, XZR_R);
    w_b_mem = rf_use_b & is_producer(w_mem.valid, w_mem.regwrite, w_mem.rd, rf_rb, XZR_R);
  end

`ifdef HAZ_FWD_EN
  always_comb begin
    w_stall     = 1'b0;
    w_fwd_a     = FWD_RF;
    w_fwd_b     = FWD_RF;
    w_fwd_flags = 1'b0;
    if (rf_valid) begin
      // Load data only exists at the end of MEM: one bubble, then MEM forward.
      w_stall = (w_a_ex | w_b_ex) & w_ex.load;
      if (w_a_ex && !w_ex.load) w_fwd_a = FWD_EX;
      else if (w_a_mem)         w_fwd_a = FWD_MEM;
      if (w_b_ex && !w_ex.load) w_fwd_b = FWD_EX;
      else if (w_b_mem)         w_fwd_b = FWD_MEM;
      // An older setter in MEM has already updated the flag register.
      w_fwd_flags = rf_use_flags & w_ex.valid & w_ex.setflag;
    end
  end
  // WB is retired (regfile writes on negedge); MEM load/setflag need no action.
  assign w_unused = ^{w_mem.load, w_mem.setflag, w_wb};
`else
  always_comb begin
    w_stall     = 1'b0;
    w_fwd_a     = FWD_RF;
    w_fwd_b     = FWD_RF;
    w_fwd_flags = 1'b0;
    if (rf_valid) begin
      w_stall = w_a_ex | w_a_mem | w_b_ex | w_b_mem |
                (rf_use_flags & ((w_ex.valid & w_ex.setflag) |
                                 (w_mem.valid & w_mem.setflag)));
    end
  end
  // Without forwarding the load distinction is irrelevant; WB is retired.
  assign w_unused = ^{w_ex.load, w_mem.load, w_wb};
`endif

  assign stall     = w_stall;
  assign bubble    = w_stall;
  assign fwd_a     = w_fwd_a;
  assign fwd_b     = w_fwd_b;
  assign fwd_flags = w_fwd_flags;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl. The bench plays the pipeline: it
// holds each instruction in RF while stall is high, counts the stall cycles
// and then checks the forwarding selects on the cycle the instruction leaves
// RF. Expected values follow the HAZ_FWD_EN build setting.
module tb_hazard_ctrl;

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rf_valid;
  logic [4:0] rf_ra, rf_rb, rf_rd;
  logic       rf_use_a, rf_use_b, rf_use_flags;
  logic       rf_regwrite, rf_load, rf_setflag;
  logic       stall, bubble, fwd_flags;
  logic [1:0] fwd_a, fwd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rf_valid     (rf_valid),
    .rf_ra        (rf_ra),
    .rf_rb        (rf_rb),
    .rf_use_a     (rf_use_a),
    .rf_use_b     (rf_use_b),
    .rf_use_flags (rf_use_flags),
    .rf_regwrite  (rf_regwrite),
    .rf_rd        (rf_rd),
    .rf_load      (rf_load),
    .rf_setflag   (rf_setflag),
    .stall        (stall),
    .bubble       (bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .fwd_flags    (fwd_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic uf, input logic rw,
                       input logic [4:0] rd, input logic ld, input logic sf);
    rf_valid = v; rf_ra = ra; rf_rb = rb;
    rf_use_a = ua; rf_use_b = ub; rf_use_flags = uf;
    rf_regwrite = rw; rf_rd = rd; rf_load = ld; rf_setflag = sf;
  endtask

  // Present one instruction in RF, hold it through any stall, check results.
  task automatic issue(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic uf, input logic rw,
                       input logic [4:0] rd, input logic ld, input logic sf,
                       input int exp_st, input logic [1:0] ea, input logic [1:0] eb,
                       input logic ef);
    int n;
    n = 0;
    drive(1'b1, ra, rb, ua, ub, uf, rw, rd, ld, sf);
    @(negedge clk);
    while (stall === 1'b1 && n < 4) begin
      check_eq({tag, ".bubble"}, 32'(bubble), 32'd1);
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check_eq({tag, ".stalls"}, 32'(n), 32'(exp_st));
    check_eq({tag, ".bubble0"}, 32'(bubble), 32'd0);
    check_eq({tag, ".fwd_a"}, 32'(fwd_a), 32'(ea));
    check_eq({tag, ".fwd_b"}, 32'(fwd_b), 32'(eb));
    check_eq({tag, ".fwd_flags"}, 32'(fwd_flags), 32'(ef));
    @(posedge clk); #1;
  endtask

  task automatic nop(input string tag);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq({tag, ".stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    // ADDS X1,X2,X3 already waiting in RF while reset is held
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.stall",  32'(stall),     32'd0);
    check_eq("rst.bubble", 32'(bubble),    32'd0);
    check_eq("rst.fwd_a",  32'(fwd_a),     32'd0);
    check_eq("rst.fwd_b",  32'(fwd_b),     32'd0);
    check_eq("rst.flags",  32'(fwd_flags), 32'd0);
    reset = 1'b0;

    // ADDS X1,X2,X3 ; ADD X1,X2,X3 ; SUB X4,X1,X5  (distance 1)
    issue("adds",   5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 1, 0, 2'b00, 2'b00, 0);
    issue("add_a",  5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("sub_d1", 5'd1, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0,
          FWD ? 0 : 2, FWD ? 2'b01 : 2'b00, 2'b00, 0);
    idle(3);

    // ADD X1 ; NOP ; SUB X4,X1,X5  (distance 2)
    issue("add_b",  5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("nop_b");
    issue("sub_d2", 5'd1, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0,
          FWD ? 0 : 1, FWD ? 2'b10 : 2'b00, 2'b00, 0);
    idle(3);

    // ADD X1 ; NOP ; NOP ; SUB X4,X1,X5  (distance 3)
    issue("add_c",  5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("nop_c1");
    nop("nop_c2");
    issue("sub_d3", 5'd1, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(3);

    // LDUR X1,[X2,#0] ; ADD X3,X1,X1  (load-use)
    issue("ldur",   5'd2, 5'd0, 1, 0, 0, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00, 0);
    issue("ld_use", 5'd1, 5'd1, 1, 1, 0, 1, 5'd3, 0, 0,
          FWD ? 1 : 2, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, 0);
    idle(3);

    // ADD X31,X2,X3 ; CBZ X31  (zero register never a hazard)
    issue("add_xzr", 5'd2, 5'd3, 1, 1, 0, 1, 5'd31, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("cbz_xzr", 5'd0, 5'd31, 0, 1, 0, 0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(3);

    // SUBS X1,X2,X3 ; B.LT  (flags, distance 1)
    issue("subs_f", 5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 1, 0, 2'b00, 2'b00, 0);
    issue("blt_d1", 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0,
          FWD ? 0 : 2, 2'b00, 2'b00, FWD ? 1'b1 : 1'b0);
    idle(3);

    // SUBS ; NOP ; B.LT  (flags, distance 2)
    issue("subs_g", 5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 1, 0, 2'b00, 2'b00, 0);
    nop("nop_g");
    issue("blt_d2", 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, FWD ? 0 : 1, 2'b00, 2'b00, 0);
    idle(3);

    // ADD X1 ; ADD X1,X6,X7 ; SUB X4,X5,X1  (EX wins over MEM on operand B)
    issue("add_h1",   5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("add_h2",   5'd6, 5'd7, 1, 1, 0, 1, 5'd1, 0, 0, 0, 2'b00, 2'b00, 0);
    issue("sub_prio", 5'd5, 5'd1, 1, 1, 0, 1, 5'd4, 0, 0,
          FWD ? 0 : 2, 2'b00, FWD ? 2'b01 : 2'b00, 0);
    idle(3);

    // rf_valid=0 masks an otherwise live operand and flag dependency
    issue("subs_i", 5'd2, 5'd3, 1, 1, 0, 1, 5'd1, 0, 1, 0, 2'b00, 2'b00, 0);
    drive(1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("inval.stall",  32'(stall),     32'd0);
    check_eq("inval.fwd_a",  32'(fwd_a),     32'd0);
    check_eq("inval.fwd_b",  32'(fwd_b),     32'd0);
    check_eq("inval.flags",  32'(fwd_flags), 32'd0);
    @(posedge clk); #1;
    idle(3);

    // Reset asserted while a load-use stall is in progress
    issue("ldur_r", 5'd2, 5'd0, 1, 0, 0, 1, 5'd1, 1, 0, 0, 2'b00, 2'b00, 0);
    drive(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rst_stall.pre", 32'(stall), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_stall.stall",  32'(stall),  32'd0);
    check_eq("rst_stall.bubble", 32'(bubble), 32'd0);
    check_eq("rst_stall.fwd_a",  32'(fwd_a),  32'd0);
    check_eq("rst_stall.fwd_b",  32'(fwd_b),  32'd0);
    reset = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage LEGv8 CPU (IF, RF, EX, MEM, WB). It keeps a private scoreboard of the destinations of in-flight instructions. Each cycle it compares them against the register and flag reads of the instruction in RF. From that comparison it drives operand-forwarding selects, flag-forwarding select, and the stall/bubble controls for the IF2RF and RF2EX pipeline registers. Branches resolve in RF with one architectural delay slot, so there is no flush logic.

## Interface
Parameters:
- REG_W, 5, register-address width
- XZR, 31, zero-register index; never a hazard source

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rf_valid  in  1  RF stage holds a real instruction
- rf_ra  in  REG_W  first read address (Rn)
- rf_rb  in  REG_W  second read address (Rm or Rd per Reg2Loc)
- rf_use_a  in  1  instruction consumes rf_ra
- rf_use_b  in  1  instruction consumes rf_rb (includes CBZ and STUR data)
- rf_use_flags  in  1  B.cond in RF
- rf_regwrite  in  1  RF instruction writes rf_rd
- rf_rd  in  REG_W  RF destination
- rf_load  in  1  RF instruction is LDUR/LDURB
- rf_setflag  in  1  RF instruction sets flags
- stall  out  1  hold PC and IF2RF
- bubble  out  1  load NOP (RegWrite=0, MemWrite=0, setFlag=0) into RF2EX
- fwd_a  out  2  operand A source: 00 regfile, 01 EX ALU result, 10 MEM result
- fwd_b  out  2  operand B source, same encoding as fwd_a
- fwd_flags  out  1  1 = use live EX flags, 0 = use flag register

## Operation
Scoreboard:
- Three entries, EX, MEM and WB. Each entry holds {valid, regwrite, rd, load, setflag}.
- On every edge the entries shift EX→MEM→WB.
- The EX entry loads the RF fields when stall=0. When stall=1 it loads an invalid entry, mirroring the bubble.
- An entry is a producer for register r only if valid & regwrite & rd==r & r!=XZR.

Forwarding, evaluated per operand when use is set and rf_valid=1:
- Priority is EX over MEM.
- EX producer, non-load → fwd=01.
- MEM producer → fwd=10. For a load, this is the MEM load data.
- Otherwise → fwd=00.
- A WB producer is never forwarded. The regfile writes on the negative edge, so an RF read in the same cycle already sees the new value.

Load-use:
- An EX-entry producer with load=1 feeding any used operand → stall=1, bubble=1 for exactly one cycle.
- On the next cycle the load sits in MEM and fwd=10 applies.

Flags:
- rf_use_flags with EX entry valid & setflag → fwd_flags=1.
- Otherwise fwd_flags=0. The flag register has already been written by any older setter.
- Flags never cause a stall.

Combining conditions: stall and bubble are always equal. Several hazards active in the same cycle still produce a single stall cycle per evaluation. Re-evaluation continues each cycle until no stall condition remains.

rf_valid=0 forces stall=0, bubble=0, fwd_a=fwd_b=00 and fwd_flags=0.

## Timing
- The scoreboard is registered. All outputs are combinational from the scoreboard plus the rf_* inputs, and are valid in the same cycle.
- Reset clears all scoreboard entries to invalid. During and after reset: stall=0, bubble=0, fwd_a=00, fwd_b=00, fwd_flags=0.
- Asserting reset during a stall clears the scoreboard on that edge. The stall drops in the following cycle.
- Forwarded EX result is the combinational ALUout/MOVout. The forward path is ALU→RF-stage mux, which is the critical path; a CBZ zero test is placed after the mux.
- Latency: dependent ALU op, 0 stall cycles. Load followed by a dependent instruction, 1 stall cycle.

## Configuration
- HAZ_FWD_EN defined (default): forwarding as described above.
- HAZ_FWD_EN undefined:
  - fwd_a, fwd_b and fwd_flags are tied to 0.
  - Any EX or MEM producer of a used operand → stall=bubble=1.
  - Any EX or MEM setflag entry while rf_use_flags=1 → stall=bubble=1.
  - Result: a dependency at distance 1 stalls 2 cycles, distance 2 stalls 1, distance 3 or more stalls 0.

## Structure
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10
  - sb_entry_t packed struct {valid, regwrite, rd, load, setflag}
  - XZR_IDX constant
- Sub-module hazard_scoreboard: the three-entry shift register with bubble insertion. It exposes its entries to the comparison logic in hazard_ctrl.

## Test plan
- Reset sequence: reset=1 for 2 cycles, then ADDS X1,X2,X3 enters RF → stall=0, fwd_a=00, fwd_b=00.
- ADD X1,X2,X3 then SUB X4,X1,X5 → in SUB's RF cycle fwd_a=01, stall=0. Same pair with one NOP between → fwd_a=10. Two NOPs between → fwd_a=00.
- LDUR X1,[X2,#0] then ADD X3,X1,X1 → one cycle stall=1, bubble=1. Next cycle fwd_a=10, fwd_b=10, stall=0.
- ADD X31,X2,X3 then CBZ X31 → fwd_b=00, stall=0.
- SUBS X1,X2,X3 then B.LT → fwd_flags=1. Same with a NOP between → fwd_flags=0.
- HAZ_FWD_EN undefined, ADD X1,.. then ADD ..,X1 → stall=1 for exactly 2 cycles, then fwd_a=00.
